// File: rtl/adder_arbiter.sv
// Purpose: shares one WIDTH-bit adder between NREQ requesters; returns {co,out} tagged with the requester id.
// Latency: 2 edges from request accept to rsp_valid; peak one addition every 3 cycles.
// Backpressure: rsp_ready low holds the response in RESP indefinitely; req_ready stays zero until it is consumed.
// Config: define ADDER_ARB_RR_EN for round-robin grant; default build is fixed priority (lowest index wins).

module adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             co
);
    // Full-width sum: the carry out becomes the top bit of the result.
    assign {co, out} = {1'b0, A} + {1'b0, B};
endmodule

module adder_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    input  logic                  rsp_ready,
    output logic                  busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH:0]   r_rsp_sum;
    logic             r_busy;

    logic             w_gnt_vld;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_out;
    logic             w_co;

`ifdef ADDER_ARB_RR_EN
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_idx;

    // Round-robin: first valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_gnt_vld && req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end
`else
    // Fixed priority: scan from the top so the lowest valid index is the last to win.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(k);
            end
        end
    end
`endif

    // The granted requester sees ready only while idle; its valid makes the handshake.
    assign w_accept  = (r_state == S_IDLE) && w_gnt_vld;
    assign req_ready = w_accept ? (NREQ'(1) << w_gnt_id) : '0;

    adder #(.WIDTH(WIDTH)) u_adder (
        .A   (r_a),
        .B   (r_b),
        .out (w_out),
        .co  (w_co)
    );

    // Control FSM with registered response and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[w_gnt_id*WIDTH +: WIDTH];
                        r_b     <= req_b[w_gnt_id*WIDTH +: WIDTH];
                        r_id    <= w_gnt_id;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rsp_sum   <= {w_co, w_out};
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Purpose: self-checking bench for adder_arbiter against a transaction-level model of grant and sum.
// Latency: expects response two edges after accept and return to idle one edge after consume.
// Backpressure: exercises rsp_ready held low in RESP and checks the response stays frozen.

module tb_adder_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  rsp_ready = 1'b0;
    logic                  busy;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    // Results captured by the driver for the calling test to judge.
    logic [NREQ-1:0] t_rdy;
    logic            t_calc_ok;
    logic            t_rsp_vld;
    logic [IDW-1:0]  t_id;
    logic [WIDTH:0]  t_sum;
    logic            t_stable;
    logic            t_idle;

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference grant: which requester should win given the current model pointer.
    function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef ADDER_ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
`endif
        return -1;
    endfunction

    function automatic int model_sum(input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b, input int g);
        int ea, eb;
        ea = int'((a >> (g * WIDTH)) & 16'hF);
        eb = int'((b >> (g * WIDTH)) & 16'hF);
        return ea + eb;
    endfunction

    // Drives one transaction starting at a negedge with the DUT idle; records observations only.
    task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                          input logic [NREQ*WIDTH-1:0] b, input int hold);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        #1 t_rdy = req_ready;
        @(posedge clk); @(negedge clk);
        t_calc_ok = busy && !rsp_valid && (req_ready == '0);
        req_valid = v | NREQ'($urandom);
        @(posedge clk); @(negedge clk);
        t_rsp_vld = rsp_valid;
        t_id      = rsp_id;
        t_sum     = rsp_sum;
        t_stable  = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); @(negedge clk);
            if (!(rsp_valid && rsp_id == t_id && rsp_sum == t_sum && req_ready == '0 && busy))
                t_stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        t_idle    = !rsp_valid && !busy;
        req_valid = '0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {rsp_valid, rsp_id, rsp_sum, busy, req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int g;
        logic [NREQ*WIDTH-1:0] a, b;
        a = 16'h0900; b = 16'h0800;
        g = model_grant(4'b0100);
        do_txn(4'b0100, a, b, 0);
        m_ptr = (g + 1) % NREQ;
        checks++;
        if (t_rdy !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", t_rdy); end
        checks++;
        if (t_calc_ok !== 1'b1) begin failures++; $display("FAIL single_calc got=%b exp=1", t_calc_ok); end
        checks++;
        if ({t_rsp_vld, t_id, t_sum} !== {1'b1, 2'd2, 5'd17}) begin
            failures++; $display("FAIL single_rsp got vld=%b id=%0d sum=%0d exp vld=1 id=2 sum=17", t_rsp_vld, t_id, t_sum);
        end
        checks++;
        if (t_idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", t_idle); end
    endtask

    task automatic test_boundary;
        int av [3] = '{15, 0, 7};
        int bv [3] = '{15, 0, 8};
        int ev [3] = '{30, 0, 15};
        for (int i = 0; i < 3; i++) begin
            int g, r;
            logic [NREQ*WIDTH-1:0] a, b;
            r = i % NREQ;
            a = (NREQ*WIDTH)'(av[i]) << (r * WIDTH);
            b = (NREQ*WIDTH)'(bv[i]) << (r * WIDTH);
            g = model_grant(NREQ'(1) << r);
            do_txn(NREQ'(1) << r, a, b, 0);
            m_ptr = (g + 1) % NREQ;
            checks++;
            if (t_sum !== 5'(ev[i]) || t_id !== IDW'(r)) begin
                failures++;
                $display("FAIL boundary_sum%0d got sum=%0d id=%0d exp sum=%0d id=%0d", i, t_sum, t_id, ev[i], r);
            end
        end
    endtask

    task automatic test_withdraw;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL withdraw_ready got=%b exp=0010", req_ready); end
        #1 req_valid = '0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin failures++; $display("FAIL withdraw_idle got=%b exp=00", {busy, rsp_valid}); end
    endtask

`ifdef ADDER_ARB_RR_EN
    task automatic test_fairness;
        for (int i = 0; i < 8; i++) begin
            int g;
            g = model_grant(4'hF);
            do_txn(4'hF, NREQ*WIDTH'($urandom), NREQ*WIDTH'($urandom), 0);
            m_ptr = (g + 1) % NREQ;
            checks++;
            if (t_rdy !== (NREQ'(1) << g) || t_id !== IDW'(g)) begin
                failures++; $display("FAIL rr_grant%0d got rdy=%b id=%0d exp id=%0d", i, t_rdy, t_id, g);
            end
        end
    endtask
`else
    task automatic test_fixed_priority;
        for (int i = 0; i < 6; i++) begin
            do_txn(4'b1001, (NREQ*WIDTH)'($urandom), (NREQ*WIDTH)'($urandom), 0);
            checks++;
            if (t_rdy !== 4'b0001 || t_id !== 2'd0) begin
                failures++; $display("FAIL fixed_grant%0d got rdy=%b id=%0d exp rdy=0001 id=0", i, t_rdy, t_id);
            end
        end
    endtask
`endif

    task automatic test_backpressure;
        int g, e;
        logic [NREQ*WIDTH-1:0] a, b;
        a = 16'h3C5A; b = 16'h9E71;
        g = model_grant(4'b1100);
        e = model_sum(a, b, g);
        do_txn(4'b1100, a, b, 5);
        m_ptr = (g + 1) % NREQ;
        checks++;
        if (t_stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", t_stable); end
        checks++;
        if (t_id !== IDW'(g) || t_sum !== 5'(e)) begin
            failures++; $display("FAIL bp_rsp got id=%0d sum=%0d exp id=%0d sum=%0d", t_id, t_sum, g, e);
        end
        checks++;
        if (t_idle !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", t_idle); end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL bp_single_hs got=%b exp=00", {rsp_valid, busy}); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            int g, e, h;
            logic [NREQ-1:0] v;
            logic [NREQ*WIDTH-1:0] a, b;
            v = NREQ'($urandom_range(1, 15));
            a = (NREQ*WIDTH)'($urandom);
            b = (NREQ*WIDTH)'($urandom);
            h = $urandom_range(0, 3);
            g = model_grant(v);
            e = model_sum(a, b, g);
            do_txn(v, a, b, h);
            m_ptr = (g + 1) % NREQ;
            checks++;
            if (t_rdy !== (NREQ'(1) << g) || t_calc_ok !== 1'b1) begin
                failures++; $display("FAIL rand_grant%0d got rdy=%b calc=%b exp rdy=%b calc=1", i, t_rdy, t_calc_ok, NREQ'(1) << g);
            end
            checks++;
            if ({t_rsp_vld, t_id, t_sum} !== {1'b1, IDW'(g), 5'(e)} || t_stable !== 1'b1 || t_idle !== 1'b1) begin
                failures++;
                $display("FAIL rand_rsp%0d got vld=%b id=%0d sum=%0d stable=%b idle=%b exp id=%0d sum=%0d", i, t_rsp_vld, t_id, t_sum, t_stable, t_idle, g, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int g;
        g = model_grant(4'hF);
        do_txn(4'hF, 16'h7777, 16'h5555, 0);
        m_ptr = (g + 1) % NREQ;
        req_valid = 4'hF;
        req_a = 16'hFFFF; req_b = 16'h1111;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, busy} !== '0) begin
            failures++; $display("FAIL reset_mid_clear got=%0h exp=0", {rsp_valid, rsp_id, rsp_sum, busy});
        end
        req_valid = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        g = model_grant(4'hF);
        do_txn(4'hF, 16'h1234, 16'h4321, 0);
        m_ptr = (g + 1) % NREQ;
        checks++;
        if (t_rdy !== 4'b0001 || t_calc_ok !== 1'b1) begin
            failures++; $display("FAIL reset_mid_regrant got rdy=%b calc=%b exp rdy=0001 calc=1", t_rdy, t_calc_ok);
        end
        checks++;
        if (t_id !== 2'd0 || t_sum !== 5'd5) begin
            failures++; $display("FAIL reset_mid_rsp got id=%0d sum=%0d exp id=0 sum=5", t_id, t_sum);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_boundary;
        test_withdraw;
`ifdef ADDER_ARB_RR_EN
        test_fairness;
`else
        test_fixed_priority;
`endif
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares a single `adder` datapath instance (WIDTH-bit, outputs `out` and `co`) between NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands and drives them into the shared adder. It then returns the (WIDTH+1)-bit sum, tagged with the requester index, on a single response channel with backpressure. It sits between the instruction-side units that need additions and the one physical adder stage.

## Interface
Parameters:
- WIDTH, 4, operand width; passed through to the internal `adder` instance.
- NREQ, 4, number of requesters (2..8); ID width is $clog2(NREQ).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  NREQ  bit i: requester i offers operands.
- req_a  in  NREQ*WIDTH  operand A of requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B of requester i, same packing.
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- rsp_valid  out  1  response available.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the response.
- rsp_sum  out  WIDTH+1  {co, out} of the shared adder.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - The grant logic picks one valid requester, combinationally from req_valid.
  - req_ready[g] = 1 for the granted g only. All bits are 0 when no requester is valid.
  - On a clock edge with req_valid[g] & req_ready[g], the block latches a_r, b_r and id_r, updates the pointer, and goes to CALC.
- CALC:
  - a_r and b_r drive adder.A and adder.B.
  - On the edge, the block captures {co, out} into rsp_sum and id_r into rsp_id, sets rsp_valid, and goes to RESP.
- RESP:
  - rsp_valid stays at 1. rsp_id and rsp_sum are held stable.
  - On an edge with rsp_ready = 1, rsp_valid clears and the FSM goes to IDLE.
- req_ready is 0 in CALC and RESP. No new request is accepted until the response has been consumed.
- Requesters must hold req_valid, req_a and req_b stable until they see ready. Dropping valid before ready is legal and withdraws the request with no side effect.
- Arithmetic: the full sum is kept in WIDTH+1 bits, so there is no overflow or wrap.
  - Example: 15 + 15 = 30 gives co = 1, out = 14.
- Grant policy: selected by the configuration macro (see Configuration).
- Reset values: state IDLE, rsp_valid 0, rsp_id 0, rsp_sum 0, busy 0, req_ready 0 (no valid requester), pointer 0, a_r/b_r/id_r 0.

## Timing
- Accept edge k: state becomes CALC.
- Edge k+1: rsp_valid = 1 with the final sum. Request-to-response latency is 2 edges.
- Earliest next accept is edge k+3, when rsp_ready = 1 at edge k+2.
  - Peak throughput is one addition per 3 cycles.
- rsp_ready held at 1 before rsp_valid rises has no effect until RESP.
- rsp_ready = 0: the block stays in RESP indefinitely. Outputs are unchanged and req_ready is all zero.
- Reset asserted in any state clears all registers immediately. Any in-flight operation and pending response are dropped; nothing is replayed after reset release.
- Reset release: the first accept can occur on the first rising edge after rst_n goes high.

## Configuration
- Macro: ADDER_ARB_RR_EN.
- Defined: round-robin grant.
  - Search starts at the pointer and wraps modulo NREQ.
  - After a grant to g, the pointer becomes (g+1) mod NREQ.
  - Any continuously valid requester is served within NREQ grants.
- Undefined: fixed priority; the lowest valid index wins.
  - The pointer register is not implemented.
  - Starvation of higher indices is permitted.

## Test plan
WIDTH = 4, NREQ = 4 unless stated.
- Single request: only requester 2 valid, a = 9, b = 8. req_ready = 0b0100 at accept; two edges later rsp_valid = 1, rsp_id = 2, rsp_sum = 17 (co = 1, out = 1).
- Boundary sums:
  - 15 + 15: rsp_sum = 30.
  - 0 + 0: rsp_sum = 0.
  - 7 + 8: rsp_sum = 15, co = 0.
- Fairness with ADDER_ARB_RR_EN: all four requesters continuously valid, rsp_ready = 1. Grant order is 0,1,2,3,0,1,... and each response rsp_id matches its grant.
- Fixed priority without ADDER_ARB_RR_EN: requesters 0 and 3 continuously valid. Every grant goes to 0 and requester 3 never sees req_ready.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP. rsp_valid, rsp_id and rsp_sum stay constant, req_ready = 0, busy = 1. Release gives exactly one response handshake, then the FSM returns to IDLE.
- Reset mid-operation: assert rst_n = 0 asynchronously during CALC. rsp_valid, rsp_id, rsp_sum and busy go to 0 at once, and no response for that operation appears after release. With RR enabled, the next grant with all valid goes to requester 0.
